// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the ROM address, buffers returned words with
// their PCs in a small shift queue, and hands them to decode over valid/ready.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'd0,
  parameter int          DEPTH        = 2,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  state_t      state;
  logic [31:0] pc;
  logic [2:0]  count;
  logic [31:0] q_inst [DEPTH];
  logic [31:0] q_pc   [DEPTH];

  logic        pop;
  logic        push;
  logic        zero_word;
  logic        do_redirect;
  logic [2:0]  wr_idx;

  assign imem_addr  = pc;
  assign inst_valid = (count != 3'd0);
  assign inst_out   = q_inst[0];
  assign inst_pc    = q_pc[0];
  assign halted     = (state == HALT);
  assign busy       = (state == FETCH);

  assign zero_word   = HALT_ON_ZERO && (imem_data == 32'h0);
  assign do_redirect = redirect_valid && (state != IDLE);
  assign pop         = inst_valid && inst_ready;
  assign push        = (state == FETCH) && !redirect_valid &&
                       ((count < DEPTH_C) || pop) && !zero_word;
  // With a simultaneous pop the tail slides down one place before the write.
  assign wr_idx      = count - {2'b00, pop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      count <= 3'd0;
      // NOTE: the queue storage is reset too so the head outputs read 0 after reset.
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= 32'h0;
        q_pc[i]   <= 32'h0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every term above sees pre-edge state.
      case (state)
        IDLE:    if (start) state <= FETCH;
        FETCH:   if (!redirect_valid && zero_word) state <= HALT;
        HALT:    if (redirect_valid) state <= FETCH;
        default: state <= IDLE;
      endcase

      if (do_redirect) begin
        pc <= redirect_target & ~32'h3;
      end else if (push) begin
        pc <= pc + 32'd4;
      end

      if (do_redirect) begin
        count <= 3'd0;
      end else if (push && !pop) begin
        count <= count + 3'd1;
      end else if (pop && !push) begin
        count <= count - 3'd1;
      end

      // Shift only occupied slots so a lone head stays put once the queue drains.
      if (pop && !redirect_valid) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (3'(i + 1) < count) begin
            q_inst[i] <= q_inst[i+1];
            q_pc[i]   <= q_pc[i+1];
          end
        end
      end

      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == 3'(i)) begin
            q_inst[i] <= imem_data;
            q_pc[i]   <= pc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a small ROM model, directed stimulus, and a scoreboard
// monitor that compares every accepted beat against the expected program order.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        halted;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } beat_t;

  beat_t exp_q[$];

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .halted          (halted),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Program ROM: a few fixed words, nonzero filler, all-zero from 68 upward.
  function automatic logic [31:0] rom(input logic [31:0] addr);
    if (addr == 32'd0)       return 32'hE2099F00;
    else if (addr == 32'd48) return 32'hE152F003;
    else if (addr == 32'd64) return 32'hE5A90008;
    else if (addr >= 32'd68) return 32'h0;
    else                     return 32'hE0000000 | addr;
  endfunction

  assign imem_data = rom(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [31:0] first_pc, input logic [31:0] last_pc);
    beat_t b;
    for (logic [31:0] a = first_pc; a <= last_pc; a += 32'd4) begin
      b.pc   = a;
      b.inst = rom(a);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    beat_t b;
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got pc %h inst %h expected no beat", inst_pc, inst_out);
      end else begin
        b = exp_q.pop_front();
        check("beat_pc", inst_pc, b.pc);
        check("beat_inst", inst_out, b.inst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    inst_ready      = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    tick();

    // Streaming from start through the halt on the zero word at 68.
    expect_run(32'd0, 32'd64);
    inst_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_addr", imem_addr, 32'd0);
    check("start_valid_n1", {31'd0, inst_valid}, 32'd0);
    tick();
    check("start_valid_n2", {31'd0, inst_valid}, 32'd1);
    check("first_pc", inst_pc, 32'd0);
    check("first_inst", inst_out, 32'hE2099F00);
    wait_halted(100);
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_addr", imem_addr, 32'd68);
    tick();
    tick();
    tick();
    check("halt_addr_hold", imem_addr, 32'd68);
    check("halt_drained", {31'd0, inst_valid}, 32'd0);
    check("hold_inst_out", inst_out, 32'hE5A90008);
    check("hold_inst_pc", inst_pc, 32'd64);

    // Redirect out of HALT with misaligned target; decode stalled.
    inst_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h00000031;
    tick();
    redirect_valid = 1'b0;
    check("resume_addr", imem_addr, 32'h30);
    check("resume_busy", {31'd0, busy}, 32'd1);
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_valid_n1", {31'd0, inst_valid}, 32'd0);
    tick();
    check("resume_valid_n2", {31'd0, inst_valid}, 32'd1);
    check("resume_pc", inst_pc, 32'd48);
    check("resume_inst", inst_out, 32'hE152F003);
    tick();
    tick();
    check("full_addr_hold", imem_addr, 32'd56);

    // Redirect with a full queue: 48 and 52 must never be delivered.
    redirect_valid  = 1'b1;
    redirect_target = 32'd12;
    tick();
    redirect_valid = 1'b0;
    check("flush_valid", {31'd0, inst_valid}, 32'd0);
    check("flush_addr", imem_addr, 32'd12);
    expect_run(32'd12, 32'd64);
    inst_ready = 1'b1;
    tick();
    check("flush_next_valid", {31'd0, inst_valid}, 32'd1);
    check("flush_next_pc", inst_pc, 32'd12);
    wait_halted(100);
    tick();
    tick();

    // Backpressure after start, then release with no gap.
    reset      = 1'b1;
    inst_ready = 1'b0;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("bp_addr", imem_addr, 32'd8);
    check("bp_valid", {31'd0, inst_valid}, 32'd1);
    check("bp_head_pc", inst_pc, 32'd0);
    expect_run(32'd0, 32'd12);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_no_gap", {31'd0, inst_valid}, 32'd1);
    end
    inst_ready = 1'b0;
    tick();
    check("bp2_addr", imem_addr, 32'd24);
    check("bp2_head_pc", inst_pc, 32'd16);

    // Asynchronous reset mid-cycle with two entries queued.
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_inst_out", inst_out, 32'h0);
    check("arst_inst_pc", inst_pc, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset      = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_no_fetch_valid", {31'd0, inst_valid}, 32'd0);
    check("idle_no_fetch_addr", imem_addr, 32'h0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
